// File: rtl/sdp_ram_ctl.sv
`default_nettype none
// ============================================================================
// Module   : sdp_ram_ctl
// Brief    : Simple dual-port RAM with sweep-clear engine and read-valid pipe
// Revision : 1.0
// ============================================================================
module sdp_ram_ctl #(
    parameter int                ADDR_W         = 8,
    parameter int                DATA_W         = 1,
    parameter int                OUT_REG        = 0,
    parameter int                RDW_MODE       = 0,
    parameter logic [DATA_W-1:0] CLEAR_VAL      = '0,
    parameter int                CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [DATA_W-1:0] read_val,
    output logic              read_valid,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_val,
    input  logic              clear,
    output logic              busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int              C_DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] C_CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam state_t          C_RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W:0]   w_cnt_next;
    logic [ADDR_W:0]   w_cnt_inc;
    logic [DATA_W-1:0] r_mem [C_DEPTH];
    logic              w_busy;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_fwd;
    logic [DATA_W-1:0] w_rd_data;
    logic              r_s1_vld;
    logic [DATA_W-1:0] r_s1_val;

    assign w_busy    = (r_state == ST_CLEAR);
    assign w_rd_acc  = read_en & ~w_busy;
    assign w_wr_acc  = write_en & ~w_busy;
    assign w_cnt_inc = r_cnt + C_CNT_ONE;
    assign busy      = w_busy;

    // The counter's extra MSB flags the final address so the sweep never wraps
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (clear) begin
                    w_state_next = ST_CLEAR;
                    w_cnt_next   = '0;
                end
            end
            ST_CLEAR: begin
                if (w_cnt_inc[ADDR_W]) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= C_RST_STATE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Storage has no reset; writes are suppressed while rst_n is held low
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_busy) begin
                r_mem[r_cnt[ADDR_W-1:0]] <= CLEAR_VAL;
            end else if (w_wr_acc) begin
                r_mem[write_addr] <= write_val;
            end
        end
    end

    assign w_fwd     = (RDW_MODE != 0) && w_wr_acc && (write_addr == read_addr);
    assign w_rd_data = w_fwd ? write_val : r_mem[read_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_val <= '0;
        end else begin
            r_s1_vld <= w_rd_acc;
            if (w_rd_acc) begin
                r_s1_val <= w_rd_data;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              r_s2_vld;
            logic [DATA_W-1:0] r_s2_val;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s2_vld <= 1'b0;
                    r_s2_val <= '0;
                end else begin
                    r_s2_vld <= r_s1_vld;
                    if (r_s1_vld) begin
                        r_s2_val <= r_s1_val;
                    end
                end
            end

            assign read_valid = r_s2_vld;
            assign read_val   = r_s2_val;
        end else begin : g_no_out_reg
            assign read_valid = r_s1_vld;
            assign read_val   = r_s1_val;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sdp_ram_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdp_ram_ctl
// Brief    : Scoreboard bench driving two sdp_ram_ctl configurations in parallel
// Revision : 1.0
// ============================================================================
module tb_sdp_ram_ctl;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        bit            known;
        int            due;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          read_en;
    logic [AW-1:0] read_addr;
    logic          write_en;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_val;
    logic          clear;
    logic [DW-1:0] read_val_a, read_val_b;
    logic          read_valid_a, read_valid_b;
    logic          busy_a, busy_b;

    // A: no output register, old-data RDW, clear to 0x00, sweep on reset
    sdp_ram_ctl #(
        .ADDR_W(AW), .DATA_W(DW), .OUT_REG(0), .RDW_MODE(0),
        .CLEAR_VAL(8'h00), .CLEAR_ON_RESET(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .read_en(read_en), .read_addr(read_addr),
        .read_val(read_val_a), .read_valid(read_valid_a), .write_en(write_en),
        .write_addr(write_addr), .write_val(write_val), .clear(clear), .busy(busy_a)
    );

    // B: output register, forwarding RDW, clear to 0xFF, idle after reset
    sdp_ram_ctl #(
        .ADDR_W(AW), .DATA_W(DW), .OUT_REG(1), .RDW_MODE(1),
        .CLEAR_VAL(8'hFF), .CLEAR_ON_RESET(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .read_en(read_en), .read_addr(read_addr),
        .read_val(read_val_b), .read_valid(read_valid_b), .write_en(write_en),
        .write_addr(write_addr), .write_val(write_val), .clear(clear), .busy(busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    logic [DW-1:0] mdl_mem   [2][DEPTH];
    bit            mdl_known [2][DEPTH];
    int            sweep_left [2];
    int            sweep_idx  [2];
    logic [DW-1:0] last_val   [2];
    bit            last_known [2];
    exp_t          q0[$];
    exp_t          q1[$];

    function automatic int lat_of(input int d);      return (d == 0) ? 1 : 2; endfunction
    function automatic bit rdw_of(input int d);      return d != 0;           endfunction
    function automatic bit cor_of(input int d);      return d == 0;           endfunction
    function automatic logic [DW-1:0] cv_of(input int d); return (d == 0) ? 8'h00 : 8'hFF; endfunction

    function automatic int q_size(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t q_front(input int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    task automatic q_push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic q_pop(input int d);
        exp_t tmp;
        if (d == 0) tmp = q0.pop_front(); else tmp = q1.pop_front();
    endtask

    // Reference behaviour for one rising edge, from the values sampled at it
    task automatic model_step(input int d);
        exp_t e;
        if (!rst_n) begin
            sweep_left[d] = cor_of(d) ? DEPTH : 0;
            sweep_idx[d]  = 0;
            if (d == 0) q0.delete(); else q1.delete();
            last_val[d]   = '0;
            last_known[d] = 1'b1;
        end else if (sweep_left[d] > 0) begin
            mdl_mem[d][sweep_idx[d]]   = cv_of(d);
            mdl_known[d][sweep_idx[d]] = 1'b1;
            sweep_idx[d]  = sweep_idx[d] + 1;
            sweep_left[d] = sweep_left[d] - 1;
        end else begin
            if (read_en) begin
                if (rdw_of(d) && write_en && (write_addr == read_addr)) begin
                    e.data  = write_val;
                    e.known = 1'b1;
                end else begin
                    e.data  = mdl_mem[d][read_addr];
                    e.known = mdl_known[d][read_addr];
                end
                e.due = cyc + lat_of(d) - 1;
                q_push(d, e);
            end
            if (write_en) begin
                mdl_mem[d][write_addr]   = write_val;
                mdl_known[d][write_addr] = 1'b1;
            end
            if (clear) begin
                sweep_left[d] = DEPTH;
                sweep_idx[d]  = 0;
            end
        end
    endtask

    task automatic mon(input int d, input logic rv, input logic [DW-1:0] val, input logic bsy);
        exp_t e;
        bit   due;
        due = 1'b0;
        if (q_size(d) > 0) begin
            e   = q_front(d);
            due = (e.due == cyc);
        end
        n_checks++;
        if (rv !== due) begin
            n_fail++;
            $display("FAIL read_valid dut%0d cyc %0d: got %b expected %b", d, cyc, rv, due);
        end
        if (due) begin
            q_pop(d);
            if (e.known) begin
                n_checks++;
                if (val !== e.data) begin
                    n_fail++;
                    $display("FAIL read_val dut%0d cyc %0d: got %h expected %h", d, cyc, val, e.data);
                end
            end
            last_val[d]   = e.data;
            last_known[d] = e.known;
        end else if (rv === 1'b1) begin
            last_known[d] = 1'b0;
        end else if (last_known[d]) begin
            n_checks++;
            if (val !== last_val[d]) begin
                n_fail++;
                $display("FAIL read_val_hold dut%0d cyc %0d: got %h expected %h", d, cyc, val, last_val[d]);
            end
        end
        n_checks++;
        if (bsy !== (sweep_left[d] > 0)) begin
            n_fail++;
            $display("FAIL busy dut%0d cyc %0d: got %b expected %b", d, cyc, bsy, sweep_left[d] > 0);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step(0);
            model_step(1);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            mon(0, read_valid_a, read_val_a, busy_a);
            mon(1, read_valid_b, read_val_b, busy_b);
        end
    end

    task automatic drive(input bit re, input logic [AW-1:0] ra, input bit we,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wv, input bit cl);
        read_en    = re;
        read_addr  = ra;
        write_en   = we;
        write_addr = wa;
        write_val  = wv;
        clear      = cl;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    // One-cycle reset pulse; outputs must drop without waiting for an edge
    task automatic reset_pulse();
        read_en  = 1'b0;
        write_en = 1'b0;
        clear    = 1'b0;
        rst_n    = 1'b0;
        #1;
        n_checks += 2;
        if (read_valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_valid dut0: got %b expected 0", read_valid_a);
        end
        if (read_valid_b !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_valid dut1: got %b expected 0", read_valid_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        read_en    = 1'b0;
        read_addr  = '0;
        write_en   = 1'b0;
        write_addr = '0;
        write_val  = '0;
        clear      = 1'b0;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++) mdl_known[d][i] = 1'b0;
            sweep_left[d] = 0;
            sweep_idx[d]  = 0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // B has no reset sweep, so initialise it while A finishes its own
        drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
        idle(17);

        for (int i = 0; i < DEPTH; i++) drive(1'b1, AW'(i), 1'b0, '0, '0, 1'b0);
        drive(1'b0, '0, 1'b1, 4'd3, 8'hA5, 1'b0);
        drive(1'b1, 4'd3, 1'b0, '0, '0, 1'b0);
        drive(1'b0, '0, 1'b1, 4'd7, 8'h11, 1'b0);
        drive(1'b1, 4'd7, 1'b1, 4'd7, 8'h3C, 1'b0);
        drive(1'b1, 4'd7, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, AW'(i), 1'b0, '0, '0, 1'b0);
        drive(1'b1, 4'd5, 1'b0, '0, '0, 1'b0);
        drive(1'b0, '0, 1'b1, 4'd5, 8'h5A, 1'b0);
        drive(1'b1, 4'd5, 1'b0, '0, '0, 1'b0);
        idle(2);

        // Clear together with a write and a read to the same word
        drive(1'b1, 4'd2, 1'b1, 4'd2, 8'h00, 1'b1);
        for (int i = 0; i < DEPTH; i++) drive(1'b1, AW'(i), 1'b1, 4'd2, 8'h77, i == 4);
        drive(1'b1, 4'd2, 1'b0, '0, '0, 1'b0);
        idle(2);

        // Reset while the sweep counter sits at 9
        drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
        idle(9);
        reset_pulse();
        for (int i = 0; i < DEPTH + 2; i++) drive(1'b1, AW'(i), 1'b0, '0, '0, 1'b0);
        drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
        idle(17);

        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] ra, wa;
            ra = AW'($urandom_range(0, DEPTH - 1));
            wa = ($urandom_range(0, 3) == 0) ? ra : AW'($urandom_range(0, DEPTH - 1));
            drive(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa,
                  DW'($urandom), $urandom_range(0, 49) == 0);
        end
        idle(DEPTH + 4);

        n_checks += 2;
        if (q0.size() != 0) begin
            n_fail++;
            $display("FAIL drain dut0: got %0d pending expected 0", q0.size());
        end
        if (q1.size() != 0) begin
            n_fail++;
            $display("FAIL drain dut1: got %0d pending expected 0", q1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
